// File: rtl/bist_pkg.sv
// bist_pkg: shared FSM states, default polynomials and the pattern-counter width helper
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;
  localparam logic [1:0]  DEF_LFSR_POLY = 2'b11;
  localparam logic [15:0] DEF_MISR_POLY = 16'h8016;
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/bist_galois_reg.sv
// bist_galois_reg: Galois shift register usable as LFSR (inject = 0) or MISR (inject = response)
//   clk, rst       clock, asynchronous active-high reset to RST_VAL
//   en             advance one step: q = (q >> 1) ^ (q[0] ? POLY : 0) ^ inject
//   load, load_val synchronous load, wins over en
//   inject         value xored into the next state
//   o_q            current register value
module bist_galois_reg #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = '1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] inject,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;
  assign w_nxt = (r_q >> 1) ^ (r_q[0] ? POLY : '0) ^ inject;
  assign o_q   = r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= RST_VAL;
    else if (load) r_q <= load_val;
    else if (en) r_q <= w_nxt;
endmodule

// File: rtl/bist_pattern_engine.sv
// bist_pattern_engine: BIST pattern generator + MISR response compactor with start/done handshake
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        begin a run (IDLE/DONE) / return to IDLE (any state but IDLE)
//   golden              expected signature, sampled on the edge entering DONE
//   pattin, pattout     pattern to the CUT / CUT response
//   busy, done, pass    RUN or DRAIN / sticky completion / signature == golden
//   signature, pat_idx  final MISR value while done / patterns applied so far
module bist_pattern_engine
  import bist_pkg::*;
#(
  parameter int              IN_W       = 2,
  parameter int              OUT_W      = 1,
  parameter int              SIG_W      = 16,
  parameter int              NUM_PAT    = 16,
  parameter int              EXHAUSTIVE = 0,
  parameter logic [IN_W-1:0] LFSR_POLY  = IN_W'(DEF_LFSR_POLY),
  parameter logic [IN_W-1:0] SEED       = IN_W'(1),
  parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(DEF_MISR_POLY),
  parameter int              CUT_LAT    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [SIG_W-1:0]            golden,
  output logic [IN_W-1:0]             pattin,
  input  logic [OUT_W-1:0]            pattout,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [SIG_W-1:0]            signature,
  output logic [idx_w(NUM_PAT)-1:0]   pat_idx
);
  localparam int IW = idx_w(NUM_PAT);
  localparam int PW = (CUT_LAT > 0) ? CUT_LAT : 1;
  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  // pipe pattern in the last DRAIN cycle: only the final valid is left, at the output stage
  localparam logic [PW-1:0] PIPE_LAST = PW'(1) << (PW - 1);
  bist_state_e r_state, w_nxt;
  logic [PW-1:0]    r_pipe;
  logic [IW-1:0]    r_idx;
  logic [SIG_W-1:0] r_gold;
  logic             r_done;
  logic [SIG_W-1:0] w_misr;
  logic [IN_W-1:0]  w_pat;
  logic w_run, w_go, w_kill, w_vld, w_last, w_fin;
  assign w_run  = r_state == RUN;
  assign w_last = w_run && r_idx == IW'(NUM_PAT - 1);
  assign w_vld  = (CUT_LAT == 0) ? w_run : r_pipe[PW-1];
  assign w_kill = abort && r_state != IDLE;
  assign w_go   = w_nxt == RUN && !w_run;
  assign w_fin  = w_nxt == DONE && r_state != DONE;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = start ? RUN : IDLE;
      RUN:     w_nxt = abort ? IDLE : w_last ? ((CUT_LAT > 0) ? DRAIN : DONE) : RUN;
      DRAIN:   w_nxt = abort ? IDLE : (r_pipe == PIPE_LAST) ? DONE : DRAIN;
      DONE:    w_nxt = abort ? IDLE : start ? RUN : DONE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx  <= '0;
      r_pipe <= '0;
      r_done <= 1'b0;
      r_gold <= '0;
    end else if (w_go || w_kill) begin
      r_idx  <= '0;
      r_pipe <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_run) r_idx <= r_idx + IW'(1);
      r_pipe <= (CUT_LAT == 0) ? '0 : (r_pipe << 1) | PW'(w_run);
      if (w_fin) begin
        r_done <= 1'b1;
        r_gold <= golden;
      end
    end
  generate
    if (EXHAUSTIVE != 0) begin : g_cnt
      logic [IN_W-1:0] r_cnt;
      always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else if (w_go) r_cnt <= '0;
        else if (w_run) r_cnt <= r_cnt + IN_W'(1);
      assign w_pat = r_cnt;
    end else begin : g_lfsr
      bist_galois_reg #(.WIDTH(IN_W), .POLY(LFSR_POLY), .RST_VAL(SEED_EFF)) u_lfsr (
        .clk(clk), .rst(rst), .en(w_run), .load(w_go), .load_val(SEED_EFF),
        .inject('0), .o_q(w_pat));
    end
  endgenerate
  // MISR is quiet in DONE (no valids), so it already holds the final signature there
  bist_galois_reg #(.WIDTH(SIG_W), .POLY(MISR_POLY), .RST_VAL('0)) u_misr (
    .clk(clk), .rst(rst), .en(w_vld), .load(w_go || w_kill), .load_val('0),
    .inject(SIG_W'(pattout)), .o_q(w_misr));
  assign pattin    = w_pat;
  assign busy      = r_state == RUN || r_state == DRAIN;
  assign done      = r_done;
  assign signature = r_done ? w_misr : '0;
  assign pass      = r_done && w_misr == r_gold;
  assign pat_idx   = r_idx;
endmodule

// File: tb/tb_bist_pattern_engine.sv
// tb_bist_pattern_engine: four engine configurations against a run-level behavioural model
module tb_bist_pattern_engine;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] golden = 4'h1;
  logic [1:0] pin [4];
  logic       pout [4];
  logic       bsy [4], dn [4], ps [4];
  logic [3:0] sg [4];
  logic [2:0] pix0, pix2, pix3;
  logic [1:0] pix1;
  logic       q2a = 1'b0, q2b = 1'b0, q3 = 1'b0;
  int checks = 0, errors = 0;
  int np [4] = '{4, 3, 4, 6};
  int lat [4] = '{0, 0, 2, 1};
  int exh [4] = '{1, 0, 1, 1};
  logic [1:0] pats [4][8];
  logic [3:0] msig [4];
  int ph [4], jj [4], hold [4];
  logic [3:0] gs [4];
  int d0, d2, b2;
  logic [3:0] s_first;
  int lseq1 [3] = '{1, 3, 2};

  always #5 clk = ~clk;

  // AND CUTs with 0, 0, 2 and 1 cycles of latency
  assign pout[0] = &pin[0];
  assign pout[1] = &pin[1];
  assign pout[2] = q2b;
  assign pout[3] = q3;
  always @(posedge clk) begin
    q2a <= &pin[2];
    q2b <= q2a;
    q3  <= &pin[3];
  end

  bist_pattern_engine #(.IN_W(2), .OUT_W(1), .SIG_W(4), .NUM_PAT(4), .EXHAUSTIVE(1),
    .LFSR_POLY(2'b11), .SEED(2'b01), .MISR_POLY(4'b1001), .CUT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden), .pattin(pin[0]),
    .pattout(pout[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .signature(sg[0]), .pat_idx(pix0));
  bist_pattern_engine #(.IN_W(2), .OUT_W(1), .SIG_W(4), .NUM_PAT(3), .EXHAUSTIVE(0),
    .LFSR_POLY(2'b11), .SEED(2'b01), .MISR_POLY(4'b1001), .CUT_LAT(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden), .pattin(pin[1]),
    .pattout(pout[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .signature(sg[1]), .pat_idx(pix1));
  bist_pattern_engine #(.IN_W(2), .OUT_W(1), .SIG_W(4), .NUM_PAT(4), .EXHAUSTIVE(1),
    .LFSR_POLY(2'b11), .SEED(2'b01), .MISR_POLY(4'b1001), .CUT_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden), .pattin(pin[2]),
    .pattout(pout[2]), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .signature(sg[2]), .pat_idx(pix2));
  bist_pattern_engine #(.IN_W(2), .OUT_W(1), .SIG_W(4), .NUM_PAT(6), .EXHAUSTIVE(1),
    .LFSR_POLY(2'b11), .SEED(2'b01), .MISR_POLY(4'b1001), .CUT_LAT(1)) u3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden), .pattin(pin[3]),
    .pattout(pout[3]), .busy(bsy[3]), .done(dn[3]), .pass(ps[3]), .signature(sg[3]), .pat_idx(pix3));

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int idx_of(input int i);
    return (i == 0) ? int'(pix0) : (i == 1) ? int'(pix1) : (i == 2) ? int'(pix2) : int'(pix3);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // pattern list per configuration and the signature its AND responses fold into
  task automatic build();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      logic [3:0] m;
      p = (exh[i] != 0) ? 2'b00 : 2'b01;
      m = 4'h0;
      for (int k = 0; k <= np[i]; k++) begin
        pats[i][k] = p;
        if (k < np[i]) m = (m >> 1) ^ (m[0] ? 4'b1001 : 4'b0000) ^ {3'b000, &p};
        p = (exh[i] != 0) ? p + 2'd1 : (p >> 1) ^ (p[0] ? 2'b11 : 2'b00);
      end
      msig[i] = m;
    end
  endtask

  // run-level model: ph 0 idle, 1 active for cycle jj of NUM_PAT+CUT_LAT, 2 done
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 4; i++)
      if (rst) begin
        ph[i] <= 0;
        jj[i] <= 0;
        hold[i] <= 0;
      end else if (ph[i] == 0) begin
        if (start) begin
          ph[i] <= 1;
          jj[i] <= 0;
        end
      end else if (ph[i] == 1) begin
        if (abort) begin
          ph[i] <= 0;
          hold[i] <= mn(jj[i] + 1, np[i]);
        end else if (jj[i] == np[i] + lat[i] - 1) begin
          ph[i] <= 2;
          gs[i] <= golden;
        end else jj[i] <= jj[i] + 1;
      end else if (abort) begin
        ph[i] <= 0;
        hold[i] <= np[i];
      end else if (start) begin
        ph[i] <= 1;
        jj[i] <= 0;
      end

  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 4; i++) begin
        int pk;
        pk = (ph[i] == 0) ? hold[i] : (ph[i] == 1) ? mn(jj[i], np[i]) : np[i];
        chk($sformatf("busy_u%0d", i), bsy[i], ph[i] == 1);
        chk($sformatf("done_u%0d", i), dn[i], ph[i] == 2);
        chk($sformatf("pattin_u%0d", i), pin[i], pats[i][pk]);
        chk($sformatf("pat_idx_u%0d", i), idx_of(i), (ph[i] == 0) ? 0 : mn(jj[i], np[i]) + ((ph[i] == 2) ? np[i] : 0) - ((ph[i] == 2) ? mn(jj[i], np[i]) : 0));
        if (ph[i] == 2) begin
          chk($sformatf("sig_u%0d", i), sg[i], msig[i]);
          chk($sformatf("pass_u%0d", i), ps[i], msig[i] == gs[i]);
        end
      end

  task automatic go(input int ign, input int abt, input int cycles);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = -1;
    d2 = -1;
    b2 = 0;
    for (int c = 0; c < cycles; c++) begin
      if (c == 0) chk("done_clr_u0", dn[0], 0);
      if (c < 4) chk("pat_seq_u0", pin[0], c);
      if (c < 3) chk("pat_seq_u1", pin[1], lseq1[c]);
      if (dn[0] && d0 < 0) d0 = c;
      if (dn[2] && d2 < 0) d2 = c;
      if (bsy[2]) b2++;
      start = (c == ign);
      abort = (c == abt);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    build();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", bsy[i], 0);
      chk("rst_done", dn[i], 0);
      chk("rst_sig", sg[i], 0);
      chk("rst_idx", idx_of(i), 0);
    end
    chk("rst_pattin_u0", pin[0], 0);
    chk("rst_pattin_u1", pin[1], 1);
    rst = 1'b0;
    // plain run: exhaustive AND, LFSR AND, latency-2 AND
    go(-1, -1, 8);
    chk("done_lat_u0", d0, 4);
    chk("done_lat_u2", d2, 6);
    chk("busy_len_u2", b2, 6);
    chk("sig_lit_u0", sg[0], 4'h1);
    chk("pass_lit_u0", ps[0], 1);
    chk("sig_lit_u1", sg[1], 4'h9);
    chk("pass_lit_u1", ps[1], 0);
    chk("sig_lit_u2", sg[2], 4'h1);
    chk("pass_lit_u2", ps[2], 1);
    s_first = sg[0];
    // rerun from DONE with a stray start in cycle 2
    go(2, -1, 8);
    chk("done_lat_ign_u0", d0, 4);
    chk("sig_rerun_u0", sg[0], s_first);
    chk("pass_ign_u0", ps[0], 1);
    // abort in cycle 2, then a fresh full run
    go(-1, 2, 3);
    chk("abort_busy_u0", bsy[0], 0);
    chk("abort_done_u0", dn[0], 0);
    chk("abort_idx_u0", idx_of(0), 0);
    go(-1, -1, 8);
    chk("after_abort_sig_u0", sg[0], 4'h1);
    chk("after_abort_done_u0", d0, 4);
    // asynchronous reset between edges in the middle of RUN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("arst_busy", bsy[i], 0);
      chk("arst_done", dn[i], 0);
      chk("arst_idx", idx_of(i), 0);
      chk("arst_sig", sg[i], 0);
    end
    chk("arst_pattin_u1", pin[1], 1);
    chk("arst_pattin_u0", pin[0], 0);
    @(negedge clk);
    rst = 1'b0;
    // random start/abort/golden traffic with occasional asynchronous resets
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 7) == 0)
        case ($urandom_range(0, 2))
          0: golden = 4'h1;
          1: golden = 4'h9;
          default: golden = 4'($urandom);
        endcase
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bist_pattern_engine.md
Name: bist_pattern_engine

Overview:
Parametrised on-chip successor to the PLI-driven pattern/response flow used in the gate-level fault-simulation cases. It generates test patterns for a circuit-under-test (CUT) in LFSR or exhaustive-counter mode. It compacts CUT responses into a MISR signature, compares the result against a golden value, and reports pass/fail through a start/done handshake. It sits between the test bench (or a top-level test controller) and any combinational or pipelined CUT.

Parameters:
IN_W, 2, CUT input width = pattin width.
OUT_W, 1, CUT output width = pattout width; must be <= SIG_W.
SIG_W, 16, MISR/signature width.
NUM_PAT, 16, patterns applied per run; must be >= 1.
EXHAUSTIVE, 0, 1 = binary counter patterns starting at 0; 0 = Galois LFSR.
LFSR_POLY, 2'b11 (IN_W bits), Galois feedback mask for the LFSR.
SEED, 1 (IN_W bits), LFSR start value; 0 is replaced by 1.
MISR_POLY, 16'h8016 (SIG_W bits), Galois feedback mask for the MISR.
CUT_LAT, 0, CUT pipeline latency in cycles (0 = combinational).

Ports:
clk  in  1  sole clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a run; sampled in IDLE or DONE.
abort  in  1  synchronous abort to IDLE; ignored in IDLE.
golden  in  SIG_W  expected signature; sampled on entry to DONE.
pattin  out  IN_W  pattern driven to the CUT.
pattout  in  OUT_W  CUT response.
busy  out  1  high in RUN or DRAIN.
done  out  1  sticky until next start, abort or rst.
pass  out  1  signature == golden; valid only while done = 1.
signature  out  SIG_W  final MISR value; held while done = 1.
pat_idx  out  clog2(NUM_PAT+1)  number of patterns applied so far.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset, including mid-run:
  - state = IDLE; busy = done = pass = 0; signature = 0; pat_idx = 0; MISR = 0; valid pipe = 0.
  - Pattern register = SEED (LFSR mode) or 0 (EXHAUSTIVE mode).
- States and transitions:
  - IDLE/DONE: start = 1 -> RUN. On that edge: pattern register reloaded, MISR = 0, pat_idx = 0, done = pass = 0.
  - RUN: each cycle pattin = pattern register. On the clock edge: pattern advances, pat_idx += 1, a valid bit enters the CUT_LAT-deep delay pipe.
    - When pat_idx reaches NUM_PAT: go to DRAIN (CUT_LAT > 0) or DONE (CUT_LAT = 0).
  - DRAIN: pattern frozen. Stays exactly CUT_LAT cycles until the last delayed valid is compacted -> DONE.
  - DONE: done = 1; signature = final MISR; pass = (final MISR == golden).
  - start while busy: ignored.
  - abort while busy: -> IDLE on the next edge; done stays 0; MISR and counters cleared. abort has priority over a same-cycle transition to DONE.
- LFSR step: next = (p >> 1) ^ (p[0] ? LFSR_POLY : 0).
- EXHAUSTIVE step: next = p + 1, wrapping modulo 2^IN_W. If NUM_PAT > 2^IN_W, patterns repeat.
- MISR update, only when the delayed valid = 1:
  - m_next = (m >> 1) ^ (m[0] ? MISR_POLY : 0) ^ zero_extend(pattout).
- Response alignment: the response for the pattern applied in cycle k is sampled at the edge ending cycle k + CUT_LAT.
- Latency: with start sampled at edge t, done rises at edge t + NUM_PAT + CUT_LAT.
- pattin stays constant outside RUN. It holds its last value after DONE until the next start.

Decomposition:
- Package bist_pkg: state enum {IDLE, RUN, DRAIN, DONE}; default poly constants; a clog2-based width function for pat_idx.
- Sub-module bist_galois_reg (WIDTH, POLY; ports en, load, load_val, inject), instantiated twice:
  - LFSR instance with inject = 0.
  - MISR instance with inject = pattout.
- The EXHAUSTIVE counter is selected by generate.

Test Plan:
- AND CUT, IN_W=2, OUT_W=1, SIG_W=4, MISR_POLY=4'b1001, EXHAUSTIVE=1, NUM_PAT=4, CUT_LAT=0, golden=4'h1:
  - Start -> pattin 0,1,2,3 over 4 cycles; responses 0,0,0,1; done at start+4; signature = 4'h1; pass = 1.
- Same setup, LFSR mode, LFSR_POLY=2'b11, SEED=2'b01, NUM_PAT=3, golden=4'h1:
  - pattin 01, 11, 10; responses 0,1,0; signature = 4'h9; pass = 0.
- CUT_LAT=2 (CUT wrapped in 2 flops), EXHAUSTIVE case above:
  - done at start+6; signature still 4'h1; busy high for 6 cycles.
- Run-time interruptions:
  - Pulse start at cycle 2 of RUN -> ignored; result identical to the first case.
  - abort at cycle 2 -> IDLE next edge; done = 0; pat_idx = 0; a new start gives a full correct run.
- Reset corner cases:
  - Assert rst asynchronously mid-RUN (between edges) -> busy/done/pat_idx/signature = 0 immediately; pattin = SEED.
  - Rerun from DONE with start -> done clears on the start edge; the second signature equals the first.
